// File: rtl/rs_encoder_lfsr.sv
// Systematic Reed-Solomon encoder over GF(2^SYM_W).
// A K-symbol message is divided by g(x) through a clocked LFSR, one symbol per cycle.
// The codeword is the captured message followed by the N-K parity symbols.
module rs_encoder_lfsr #(
  parameter int unsigned     SYM_W        = 4,
  parameter int unsigned     N            = 15,
  parameter int unsigned     K            = 9,
  parameter logic [SYM_W:0]  PRIM_POLY    = 5'b10011,
  parameter                  GEN_POLY     = 24'h793CAC,
  parameter bit              TOGGLE_START = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [K*SYM_W-1:0]   message,
  input  logic                 encodeMessage,
  output logic [N*SYM_W-1:0]   encodedMessage,
  output logic                 encoderBusy,
  output logic                 encodeDone
);

  localparam int unsigned M      = N - K;
  localparam int unsigned MSG_W  = K * SYM_W;
  localparam int unsigned PAR_W  = M * SYM_W;
  localparam int unsigned CNT_W  = $clog2(K + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Reject parameter sets that cannot form a valid code
  if (N > (2 ** SYM_W) - 1) begin : gBadN
    $error("rs_encoder_lfsr: N exceeds 2^SYM_W-1");
  end
  if (K < 1 || K >= N) begin : gBadK
    $error("rs_encoder_lfsr: K must satisfy 1 <= K < N");
  end
  if ($bits(GEN_POLY) != PAR_W) begin : gBadGen
    $error("rs_encoder_lfsr: GEN_POLY width must be (N-K)*SYM_W");
  end

  localparam logic [PAR_W-1:0] GEN = PAR_W'(GEN_POLY);

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [MSG_W-1:0]  msgShift;
  logic [MSG_W-1:0]  msgHold;
  logic [PAR_W-1:0]  lfsr;
  logic [PAR_W-1:0]  lfsrNext;
  logic [SYM_W-1:0]  feedback;
  logic [CNT_W-1:0]  symCnt;
  logic              reqLevelPrev;
  logic              req;

  // Multiply by a GF(2^SYM_W) constant; with b constant this folds to XOR gates
  function automatic logic [SYM_W-1:0] gfMul(input logic [SYM_W-1:0] a,
                                             input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] t;
    acc = '0;
    t   = a;
    for (int i = 0; i < int'(SYM_W); i++) begin
      if (b[i]) acc = acc ^ t;
      t = t[SYM_W-1] ? ((t << 1) ^ PRIM_POLY[SYM_W-1:0]) : (t << 1);
    end
    return acc;
  endfunction

  // Request detect: level change in toggle mode, plain level in pulse mode
  always_comb begin
    req = TOGGLE_START ? (encodeMessage ^ reqLevelPrev) : encodeMessage;
  end

  // One LFSR division step: feedback scaled by each generator coefficient
  always_comb begin
    feedback = msgShift[MSG_W-1 -: SYM_W] ^ lfsr[PAR_W-1 -: SYM_W];
    lfsrNext = lfsr << SYM_W;
    for (int j = 0; j < int'(M); j++) begin
      lfsrNext[j*SYM_W +: SYM_W] = lfsrNext[j*SYM_W +: SYM_W]
                                   ^ gfMul(feedback, GEN[j*SYM_W +: SYM_W]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = SHIFT;
      SHIFT:   if (symCnt == CNT_W'(K - 1)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqLevelPrev   <= 1'b0;
      msgShift       <= '0;
      msgHold        <= '0;
      lfsr           <= '0;
      symCnt         <= '0;
      encodedMessage <= '0;
      encoderBusy    <= 1'b0;
      encodeDone     <= 1'b0;
    end else begin
      reqLevelPrev <= encodeMessage;
      encodeDone   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            msgShift    <= message;
            msgHold     <= message;
            lfsr        <= '0;
            symCnt      <= '0;
            encoderBusy <= 1'b1;
          end
        end
        SHIFT: begin
          lfsr     <= lfsrNext;
          msgShift <= msgShift << SYM_W;
          symCnt   <= symCnt + CNT_W'(1);
        end
        DONE: begin
          encodedMessage <= {msgHold, lfsr};
          encoderBusy    <= 1'b0;
          encodeDone     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
